// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction loader: RV32 opcodes, bundle type codes,
// loader state encoding and the word-index to byte-address helper.
package instr_mem_loader_pkg;

  localparam logic [6:0] opcode_R = 7'b0110011;
  localparam logic [6:0] opcode_I = 7'b0010011;

  localparam logic TYPE_R = 1'b0;
  localparam logic TYPE_I = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] byte_addr(input logic [31:0] word_idx);
    return word_idx << 2;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Decoded field bundle with valid/ready handshake between a producer and the loader.
interface instr_mem_loader_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        type_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [11:0] imm_i;

  modport master (
    output in_valid_i, type_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  in_ready_o
  );

  modport slave (
    input  in_valid_i, type_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output in_ready_o
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational packer: R-type or I-type field bundle to a 32-bit RV32 instruction word.
module instr_field_encoder
  import instr_mem_loader_pkg::*;
(
  input  logic        type_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o
);

  // imm sits in [31:20] untouched; srai's funct7 bits arrive pre-packed in imm[11:5]
  always_comb begin
    word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_R};
    if (type_i == TYPE_I) begin
      word_o = {imm_i, rs1_i, funct3_i, rd_i, opcode_I};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Session-based instruction memory writer: packs accepted field bundles and writes
// them to consecutive word addresses from 0, one registered write per transfer.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             finish_i,
  instr_mem_loader_if.slave bus,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_data;
  logic               r_ovf;
  logic [31:0]        w_word;
  logic               w_full;
  logic               w_ready;
  logic               w_xfer;
  logic               w_open;

  instr_field_encoder u_enc (
    .type_i   (bus.type_i),
    .rd_i     (bus.rd_i),
    .rs1_i    (bus.rs1_i),
    .rs2_i    (bus.rs2_i),
    .funct3_i (bus.funct3_i),
    .funct7_i (bus.funct7_i),
    .imm_i    (bus.imm_i),
    .word_o   (w_word)
  );

  // Ready comes only from registered state so it never loops back through in_valid
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_ready = (r_state == ST_LOAD) && !w_full;
  assign w_xfer  = bus.in_valid_i && w_ready;
  assign w_open  = start_i && (r_state != ST_LOAD);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i)  w_state_nxt = ST_LOAD;
      ST_LOAD: if (finish_i) w_state_nxt = ST_DONE;
      ST_DONE: if (start_i)  w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_xfer;
      if (w_xfer) begin
        r_addr <= byte_addr(32'(r_cnt));
        r_data <= w_word;
        r_cnt  <= r_cnt + 1'b1;
      end
      // A session open and a transfer are mutually exclusive: transfers need LOAD
      if (w_open) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if ((r_state == ST_LOAD) && bus.in_valid_i && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.in_ready_o = w_ready;
  assign mem_we_o       = r_we;
  assign mem_addr_o     = r_addr;
  assign mem_data_o     = r_data;
  assign count_o        = r_cnt;
  assign busy_o         = (r_state == ST_LOAD);
  assign done_o         = (r_state == ST_DONE);
  assign overflow_o     = r_ovf;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction stream that Control decodes. Accepts decoded RV32 R-type/I-type fields over a valid/ready handshake, packs each one into a 32-bit instruction word, and writes the words sequentially into instruction memory from byte address 0. Used by testbenches and the boot path to load programs before the single-cycle CPU runs.

Parameters:
DEPTH, 256, instruction memory capacity in 32-bit words (power of two, at least 2)
CNT_W, $clog2(DEPTH)+1, width of the word counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  open a load session (honoured only in IDLE or DONE)
finish_i  in  1  close the current session
in_valid_i  in  1  field bundle valid
in_ready_o  out  1  loader can accept a bundle
type_i  in  1  0 = R-type (opcode_R), 1 = I-type (opcode_I)
rd_i  in  5  destination register
rs1_i  in  5  source register 1
rs2_i  in  5  source register 2 (R-type only)
funct3_i  in  3  funct3
funct7_i  in  7  funct7 (R-type only)
imm_i  in  12  immediate (I-type only; caller supplies the srai funct7 bits in imm[11:5])
mem_we_o  out  1  instruction memory write enable
mem_addr_o  out  32  byte address (word index × 4)
mem_data_o  out  32  encoded instruction
count_o  out  CNT_W  words written in the current session
busy_o  out  1  state is LOAD
done_o  out  1  state is DONE (level)
overflow_o  out  1  sticky: a valid bundle was presented while the memory was full

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on rst_i.
- Reset: state = IDLE. mem_we_o=0, mem_addr_o=0, mem_data_o=0, count_o=0, in_ready_o=0, busy_o=0, done_o=0, overflow_o=0.
- Reset asserted mid-session drops any pending write. mem_we_o is 0 in the cycle after reset is sampled.
- States: IDLE, LOAD, DONE.
  - IDLE --start_i--> LOAD. On entry to LOAD: count and write pointer cleared, overflow_o cleared.
  - LOAD --finish_i--> DONE.
  - DONE --start_i--> LOAD, with the same clears as above.
  - start_i in LOAD is ignored. finish_i outside LOAD is ignored.
- in_ready_o = (state==LOAD) && (count < DEPTH). It is combinational from registered state only and never depends on in_valid_i.
- Transfer: in_valid_i && in_ready_o at a rising edge.
- Latency: one cycle. A bundle accepted at edge N appears at edge N with mem_we_o=1, mem_addr_o = ptr×4 and mem_data_o = encoded word, all registered and held for exactly one cycle. count_o and ptr increment at the same edge.
- One write per cycle. Back-to-back transfers produce consecutive addresses with no bubbles.
- mem_we_o=0 in every cycle without a transfer. mem_addr_o and mem_data_o hold their last value.
- Encoding, R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- Encoding, I-type: {imm, rs1, funct3, rd, 7'b0010011}. No sign extension is needed; imm occupies [31:20] directly.
- Simultaneous finish_i and a transfer in LOAD: the transfer is taken and written, and the state moves to DONE at that same edge.
- Full: once count==DEPTH, in_ready_o=0. in_valid_i=1 while in LOAD and full sets overflow_o. overflow_o stays set until the next session start or reset.
- The pointer never wraps. The last address written is (DEPTH-1)×4.
- count_o holds its value in DONE, so it reports program length.

Decomposition:
- opcode_R and opcode_I come from the shared header.v constants and are not redefined.
- Add TYPE_R/TYPE_I encodings and the state encodings for IDLE/LOAD/DONE to header.v.
- One combinational sub-module, instr_field_encoder: inputs are the fields and type, output is the 32-bit word. It is instantiated once ahead of the output registers.

Test Plan:
- Reset, start_i, then one R-type bundle (rd=3, rs1=1, rs2=2, funct3=0, funct7=0) -> one cycle later mem_we_o=1, mem_addr_o=0, mem_data_o=0x002081B3, count_o=1.
- Back-to-back: I-type addi (rd=5, rs1=0, imm=0xFFF, funct3=0), then R-type mul (rd=4, rs1=1, rs2=2, funct7=1), then I-type srai (rd=6, rs1=6, funct3=5, imm=0x402) -> consecutive writes of 0xFFF00293@0x0, 0x02208233@0x4, 0x40235313@0x8 with no gaps; count_o=3.
- Backpressure and full with DEPTH=4: hold in_valid_i high for 6 bundles -> exactly 4 writes (addresses 0x0 to 0xC), in_ready_o drops after the 4th, overflow_o=1, count_o=4.
- finish_i in the same cycle as the last transfer -> that write occurs and done_o=1 at the same edge. Later in_valid_i pulses produce no writes. A subsequent start_i -> count_o=0, overflow_o=0, and the next write lands at address 0.
- rst_i asserted the cycle after a transfer, then released -> mem_we_o=0 in the cycle after reset is sampled, all outputs return to their reset values, and in_ready_o=0 until start_i.
- start_i pulsed mid-LOAD after 2 writes -> ignored: the next write goes to 0x8 and count_o=3.
